// File: rtl/gpu_ram_multiread.sv
// gpu_ram_multiread: one RAM shared by CHANNELS sequenced GPU read channels plus a host R/W port.
// Optional GPU_RAM_ADDR_BOUND_EN: range-check addresses against NUM_WORDS and drive addr_fault.

module gpu_ram_mr_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  always_comb hold_d = we ? din : hold_q;
  always_ff @(posedge clk) hold_q <= hold_d;
  assign dout = hold_q;
endmodule

module gpu_ram_multiread #(
  parameter int ADDR_SIZE  = 14,
  parameter int NUM_WORDS  = 2**ADDR_SIZE,
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int CMD_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [3:0]                     pc_ena_in,
  input  logic [20*CHANNELS-1:0]         addr_in,
  input  logic [CMD_WIDTH-1:0]           cmd_in,
  output logic [20*CHANNELS-1:0]         addr_out,
  output logic [CMD_WIDTH-1:0]           cmd_out,
  output logic [3:0]                     pc_ena_out,
  output logic [DATA_WIDTH*CHANNELS-1:0] data_out,
  output logic                           data_valid,
  output logic                           overrun,
  input  logic                           wr_en_b,
  input  logic [19:0]                    addr_b,
  input  logic [DATA_WIDTH-1:0]          data_in_b,
  output logic [DATA_WIDTH-1:0]          data_out_b
`ifdef GPU_RAM_ADDR_BOUND_EN
  ,
  output logic                           addr_fault
`endif
);
  localparam int SLOT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);
  localparam int STAGES = 4;
`ifdef GPU_RAM_ADDR_BOUND_EN
  localparam bit BOUND_EN = 1'b1;
`else
  localparam bit BOUND_EN = 1'b0;
`endif

  typedef enum logic {IDLE, ISSUE} state_t;
  typedef struct packed {
    logic [CHANNELS-1:0][19:0] addr;
    logic [CMD_WIDTH-1:0]      cmd;
    logic [3:0]                pc_ena;
  } meta_t;

  function automatic logic out_of_range(input logic [19:0] a);
    return BOUND_EN && ({12'd0, a} >= 32'(NUM_WORDS));
  endfunction

  // ---------------- sequencer ----------------
  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              at_last, accept, issue_vld, issue_last, ovr_set;

  assign at_last = (slot_q == LAST_SLOT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (accept) begin
      state_d = ISSUE;
      slot_d  = '0;
    end else if (issue_last) begin
      state_d = IDLE;
      slot_d  = '0;
    end else if (issue_vld) begin
      slot_d = slot_q + 1'b1;
    end
  end

  // A strobe on the final issue slot is a legal back-to-back capture.
  always_comb begin
    issue_vld  = (state_q == ISSUE);
    issue_last = issue_vld && at_last;
    accept     = pc_ena_in[0] && (!issue_vld || at_last);
    ovr_set    = pc_ena_in[0] && issue_vld && !at_last;
  end

  // ---------------- capture bank and metadata delay ----------------
  meta_t bank_q, bank_d;
  meta_t meta_q [1:3];
  meta_t meta_d [1:3];

  always_comb begin
    bank_d = bank_q;
    if (accept) begin
      bank_d.addr   = addr_in;
      bank_d.cmd    = cmd_in;
      bank_d.pc_ena = pc_ena_in;
    end
    meta_d[1] = bank_q;
    meta_d[2] = meta_q[1];
    meta_d[3] = meta_q[2];
  end

  always_ff @(posedge clk) begin
    bank_q <= bank_d;
    meta_q <= meta_d;
  end

  // ---------------- RAM ----------------
  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
  logic [19:0]           issue_addr;
  logic [ADDR_SIZE-1:0]  idx_a, idx_b;
  logic                  wr_b;
  logic [DATA_WIDTH-1:0] ram_a_q, rd_b_q, data_out_b_q;
  logic                  rd_b_oor_q;

  assign issue_addr = bank_q.addr[slot_q];
  assign idx_a      = issue_addr[ADDR_SIZE-1:0];
  assign idx_b      = addr_b[ADDR_SIZE-1:0];
  assign wr_b       = wr_en_b && !out_of_range(addr_b);

  // Read-first on both ports: a same-edge write is seen by later reads only.
  always_ff @(posedge clk) begin
    if (wr_b) mem[idx_b] <= data_in_b;
    ram_a_q      <= mem[idx_a];
    rd_b_q       <= mem[idx_b];
    rd_b_oor_q   <= out_of_range(addr_b);
    data_out_b_q <= rd_b_oor_q ? '0 : rd_b_q;
  end
  assign data_out_b = data_out_b_q;

  // ---------------- port A read pipeline ----------------
  logic                  a_vld_q, a_vld_d, d_vld_q, d_vld_d;
  logic [SLOT_W-1:0]     a_slot_q, a_slot_d, d_slot_q, d_slot_d;
  logic                  a_oor_q, a_oor_d, d_oor_q, d_oor_d;
  logic [DATA_WIDTH-1:0] ram_d_q, ram_d_d;
  logic [STAGES:1]       vld_pipe_q, vld_pipe_d;
  logic                  overrun_q, overrun_d;

  always_comb begin
    a_vld_d    = issue_vld;
    a_slot_d   = slot_q;
    a_oor_d    = out_of_range(issue_addr);
    d_vld_d    = a_vld_q;
    d_slot_d   = a_slot_q;
    d_oor_d    = a_oor_q;
    ram_d_d    = a_oor_q ? '0 : ram_a_q;
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], issue_last};
    overrun_d  = overrun_q | ovr_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_vld_q    <= 1'b0;
      d_vld_q    <= 1'b0;
      vld_pipe_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      a_vld_q    <= a_vld_d;
      d_vld_q    <= d_vld_d;
      vld_pipe_q <= vld_pipe_d;
      overrun_q  <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    a_slot_q <= a_slot_d;
    a_oor_q  <= a_oor_d;
    d_slot_q <= d_slot_d;
    d_oor_q  <= d_oor_d;
    ram_d_q  <= ram_d_d;
  end

  logic [CHANNELS-1:0][DATA_WIDTH-1:0] hold;
  logic [CHANNELS-1:0]                 lane_we;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    assign lane_we[k] = d_vld_q && (d_slot_q == SLOT_W'(k));
    gpu_ram_mr_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk  (clk),
      .we   (lane_we[k]),
      .din  (ram_d_q),
      .dout (hold[k])
    );
  end

  // ---------------- aligned outputs ----------------
  logic [20*CHANNELS-1:0]         addr_out_q, addr_out_d;
  logic [CMD_WIDTH-1:0]           cmd_out_q, cmd_out_d;
  logic [3:0]                     pc_ena_out_q, pc_ena_out_d;
  logic [DATA_WIDTH*CHANNELS-1:0] data_out_q, data_out_d;

  always_comb begin
    addr_out_d   = addr_out_q;
    cmd_out_d    = cmd_out_q;
    pc_ena_out_d = pc_ena_out_q;
    data_out_d   = data_out_q;
    if (vld_pipe_q[STAGES-1]) begin
      addr_out_d   = meta_q[3].addr;
      cmd_out_d    = meta_q[3].cmd;
      pc_ena_out_d = meta_q[3].pc_ena;
      data_out_d   = hold;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_out_q   <= '0;
      cmd_out_q    <= '0;
      pc_ena_out_q <= '0;
      data_out_q   <= '0;
    end else begin
      addr_out_q   <= addr_out_d;
      cmd_out_q    <= cmd_out_d;
      pc_ena_out_q <= pc_ena_out_d;
      data_out_q   <= data_out_d;
    end
  end

  assign addr_out   = addr_out_q;
  assign cmd_out    = cmd_out_q;
  assign pc_ena_out = pc_ena_out_q;
  assign data_out   = data_out_q;
  assign data_valid = vld_pipe_q[STAGES];
  assign overrun    = overrun_q;

`ifdef GPU_RAM_ADDR_BOUND_EN
  logic [CHANNELS-1:0] hold_oor_q, hold_oor_d;
  logic                gpu_fault_q, gpu_fault_d, host_fault_q, host_fault_d;

  always_comb begin
    for (int k = 0; k < CHANNELS; k++)
      hold_oor_d[k] = lane_we[k] ? d_oor_q : hold_oor_q[k];
    gpu_fault_d  = vld_pipe_q[STAGES-1] && (|hold_oor_q);
    host_fault_d = rd_b_oor_q;
  end

  always_ff @(posedge clk) hold_oor_q <= hold_oor_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      gpu_fault_q  <= 1'b0;
      host_fault_q <= 1'b0;
    end else begin
      gpu_fault_q  <= gpu_fault_d;
      host_fault_q <= host_fault_d;
    end
  end

  assign addr_fault = gpu_fault_q | host_fault_q;
`else
  // Upper address bits and range flags only matter when bounds checking is built in.
  logic unused_bits;
  assign unused_bits = ^{addr_b, issue_addr, d_oor_q};
`endif
endmodule

// File: tb/tb_gpu_ram_multiread.sv
// Scoreboard bench for gpu_ram_multiread (CHANNELS=4); bound tests build with GPU_RAM_ADDR_BOUND_EN.
module tb_gpu_ram_multiread;
  localparam int CH  = 4;
  localparam int LAT = CH + 3;
`ifdef GPU_RAM_ADDR_BOUND_EN
  localparam int NW = 12000;
`else
  localparam int NW = 16384;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  pc_ena_in;
  logic [79:0] addr_in;
  logic [15:0] cmd_in;
  logic [79:0] addr_out;
  logic [15:0] cmd_out;
  logic [3:0]  pc_ena_out;
  logic [31:0] data_out;
  logic        data_valid, overrun;
  logic        wr_en_b;
  logic [19:0] addr_b;
  logic [7:0]  data_in_b, data_out_b;
`ifdef GPU_RAM_ADDR_BOUND_EN
  logic        addr_fault;
`endif

  gpu_ram_multiread #(
    .ADDR_SIZE(14), .NUM_WORDS(NW), .DATA_WIDTH(8), .CHANNELS(CH), .CMD_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .pc_ena_in(pc_ena_in), .addr_in(addr_in), .cmd_in(cmd_in),
    .addr_out(addr_out), .cmd_out(cmd_out), .pc_ena_out(pc_ena_out), .data_out(data_out),
    .data_valid(data_valid), .overrun(overrun), .wr_en_b(wr_en_b), .addr_b(addr_b),
    .data_in_b(data_in_b), .data_out_b(data_out_b)
`ifdef GPU_RAM_ADDR_BOUND_EN
    , .addr_fault(addr_fault)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [79:0] addr;
    logic [15:0] cmd;
    logic [3:0]  pc;
    logic [31:0] data;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [79:0] p4(input logic [19:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  // Drive one capture strobe; the inputs are scrambled right after so the capture bank is exercised.
  task automatic strobe(input logic [79:0] a, input logic [15:0] c, input logic [3:0] pc,
                        input logic [31:0] d, input bit expect_it, input logic f);
    addr_in = a; cmd_in = c; pc_ena_in = pc;
    tick();
    if (expect_it) sb.push_back('{addr: a, cmd: c, pc: pc, data: d, fault: f, cyc: cyc + LAT});
    addr_in = '1; cmd_in = '1; pc_ena_in = 4'b1110;
  endtask

  task automatic hw(input logic [19:0] a, input logic [7:0] d);
    addr_b = a; data_in_b = d; wr_en_b = 1'b1;
    tick();
    wr_en_b = 1'b0;
  endtask

  task automatic hr(input string name, input logic [19:0] a, input logic [7:0] d);
    addr_b = a;
    tick();
    tick();
    chk(name, data_out_b, d);
  endtask

  always @(negedge clk) begin
    if (data_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", data_valid, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("valid_cycle", cyc, mon_e.cyc);
        chk("data_out", data_out, mon_e.data);
        chk("addr_out", addr_out, mon_e.addr);
        chk("cmd_out", cmd_out, mon_e.cmd);
        chk("pc_ena_out", pc_ena_out, mon_e.pc);
`ifdef GPU_RAM_ADDR_BOUND_EN
        chk("gpu_fault", addr_fault, mon_e.fault);
`endif
      end
    end
  end

  initial begin
    pc_ena_in = '0; addr_in = '0; cmd_in = '0;
    wr_en_b = 1'b0; addr_b = '0; data_in_b = '0;
    idle(3);
    chk("rst_data_valid", data_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_addr_out", addr_out, 80'h0);
    chk("rst_cmd_out", cmd_out, 16'h0);
    chk("rst_pc_ena_out", pc_ena_out, 4'h0);
`ifdef GPU_RAM_ADDR_BOUND_EN
    chk("rst_addr_fault", addr_fault, 1'b0);
`endif
    reset = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) hw(20'(i), 8'(i + 16));
    hr("host_rd3", 20'd3, 8'h13);
    // Port B read-during-write returns the old word, then the new one.
    addr_b = 20'd15; data_in_b = 8'hEE; wr_en_b = 1'b1;
    tick();
    wr_en_b = 1'b0;
    tick();
    chk("host_rdw_old", data_out_b, 8'h1F);
    idle(2);
    chk("host_rdw_new", data_out_b, 8'hEE);

    // Fill
    strobe(p4(3, 2, 1, 0), 16'hA5A5, 4'b0001, 32'h13121110, 1'b1, 1'b0);
    idle(10);

    // Back-to-back, 4 clocks apart
    strobe(p4(3, 2, 1, 0), 16'h1111, 4'b1011, 32'h13121110, 1'b1, 1'b0);
    idle(3);
    strobe(p4(4, 7, 5, 6), 16'h2222, 4'b0101, 32'h14171516, 1'b1, 1'b0);
    idle(12);
    chk("overrun_b2b", overrun, 1'b0);

    // Overrun: second strobe 2 clocks after the first is dropped
    strobe(p4(8, 9, 10, 11), 16'h3333, 4'b0011, 32'h18191A1B, 1'b1, 1'b0);
    idle(1);
    strobe(p4(12, 13, 14, 0), 16'h4444, 4'b0001, 32'h0, 1'b0, 1'b0);
    idle(12);
    chk("overrun_set", overrun, 1'b1);
    idle(5);
    chk("overrun_sticky", overrun, 1'b1);

    // Collision: host writes addr 5 on the edge channel 0 reads it
    strobe(p4(0, 1, 2, 5), 16'h5555, 4'b0001, 32'h10111215, 1'b1, 1'b0);
    hw(20'd5, 8'hFF);
    idle(10);
    strobe(p4(5, 5, 5, 5), 16'h6666, 4'b1001, 32'hFFFFFFFF, 1'b1, 1'b0);
    idle(12);

    // Reset at slot 2; host write on the reset clock still lands
    strobe(p4(1, 2, 3, 4), 16'h7777, 4'b0001, 32'h0, 1'b0, 1'b0);
    idle(2);
    reset = 1'b1; addr_b = 20'd20; data_in_b = 8'h5A; wr_en_b = 1'b1;
    tick();
    reset = 1'b0; wr_en_b = 1'b0;
    chk("mid_rst_valid", data_valid, 1'b0);
    chk("mid_rst_data_out", data_out, 32'h0);
    chk("mid_rst_addr_out", addr_out, 80'h0);
    chk("mid_rst_cmd_out", cmd_out, 16'h0);
    chk("mid_rst_pc_ena_out", pc_ena_out, 4'h0);
    chk("mid_rst_overrun", overrun, 1'b0);
    idle(12);
    hr("rst_host_wr", 20'd20, 8'h5A);
    strobe(p4(4, 3, 2, 1), 16'h8888, 4'b0001, 32'h14131211, 1'b1, 1'b0);
    idle(10);

`ifdef GPU_RAM_ADDR_BOUND_EN
    hw(20'd11999, 8'h77);
    strobe(p4(1, 20'hFFFFF, 11999, 12000), 16'h9999, 4'b0001, 32'h11007700, 1'b1, 1'b1);
    idle(10);
    hw(20'd13000, 8'h99);
    hr("bound_host_rd", 20'd13000, 8'h00);
    chk("bound_host_fault", addr_fault, 1'b1);
    addr_b = 20'd0;
    idle(2);
    chk("bound_fault_clear", addr_fault, 1'b0);
`else
    // Upper address bits are ignored: 0x04003 aliases word 3
    strobe(p4(20'h04003, 0, 0, 0), 16'h9999, 4'b0001, 32'h13101010, 1'b1, 1'b0);
    idle(10);
`endif

    idle(12);
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
